resp_misr_compactor: RTL

Downstream response compactor for the combinational test netlist. It consumes the netlist's 8-bit output vector once per applied pattern over a valid/ready handshake and folds each vector into a multiple-input signature register (MISR). After a programmed number of patterns it compares the signature against a golden value and reports pass/fail. It sits between the netlist outputs and the test controller, and turns many cycles of response data into a single verdict.

---
 rtl/resp_misr_compactor_pkg.sv | 35 +++
 rtl/resp_misr_compactor_if.sv | 38 +++
 rtl/resp_misr_compactor_misr_reg.sv | 39 +++
 rtl/resp_misr_compactor.sv | 108 ++++++++++
 4 files changed

// File: rtl/resp_misr_compactor_pkg.sv
// Shared types and the MISR step function for the response compactor.
// Build option RESP_MISR_XMASK_EN adds a per-bit response mask.
package resp_misr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] DEF_POLY = 16'h1021;
    localparam logic [15:0] DEF_SEED = 16'h0000;

    // Widest signature the step function supports; callers pass their width.
    localparam int MISR_MAX_W = 64;

    function automatic logic [MISR_MAX_W-1:0] misr_step(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] data,
        input logic [MISR_MAX_W-1:0] poly,
        input int unsigned           w
    );
        logic [MISR_MAX_W-1:0] mask;
        logic                  fb;
        if (w >= MISR_MAX_W) begin
            mask = '1;
        end else begin
            mask = (64'd1 << w) - 64'd1;
        end
        fb = |(sig & (64'd1 << (w - 1)));
        misr_step = ((sig << 1) ^ (fb ? poly : '0) ^ data) & mask;
    endfunction

endpackage

// File: rtl/resp_misr_compactor_if.sv
// Response handshake between the netlist outputs and the compactor.
// Build option RESP_MISR_XMASK_EN adds resp_xmask.
interface resp_misr_compactor_if #(
    parameter int RESP_W = 8
);
    logic              resp_valid;
    logic              resp_ready;
    logic [RESP_W-1:0] resp_data;
`ifdef RESP_MISR_XMASK_EN
    logic [RESP_W-1:0] resp_xmask;

    modport master (
        output resp_valid,
        output resp_data,
        output resp_xmask,
        input  resp_ready
    );

    modport slave (
        input  resp_valid,
        input  resp_data,
        input  resp_xmask,
        output resp_ready
    );
`else
    modport master (
        output resp_valid,
        output resp_data,
        input  resp_ready
    );

    modport slave (
        input  resp_valid,
        input  resp_data,
        output resp_ready
    );
`endif
endinterface

// File: rtl/resp_misr_compactor_misr_reg.sv
// Signature register with polynomial feedback and parallel data injection.
// Loads SEED on reset or load; folds data in on shift.
module misr_reg
    import resp_misr_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED  = DEF_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [SIG_W-1:0] data,
    output logic [SIG_W-1:0] sig
);

    logic [MISR_MAX_W-1:0] step_full;
    logic                  unused_ok;

    assign step_full = misr_step(
        MISR_MAX_W'(sig),
        MISR_MAX_W'(data),
        MISR_MAX_W'(POLY),
        SIG_W
    );

    // The step result is already masked to SIG_W; upper bits are zero.
    assign unused_ok = ^step_full;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            sig <= SEED;
        end else if (shift) begin
            sig <= step_full[SIG_W-1:0];
        end
    end

endmodule

// File: rtl/resp_misr_compactor.sv
// Response compactor: counts patterns, folds them into a MISR, checks golden.
// Build option RESP_MISR_XMASK_EN zeroes masked response bits before folding.
module resp_misr_compactor
    import resp_misr_pkg::*;
#(
    parameter int               RESP_W = 8,
    parameter int               SIG_W  = 16,
    parameter int               CNT_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = DEF_POLY,
    parameter logic [SIG_W-1:0] SEED   = DEF_SEED
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_W-1:0]      pat_count,
    resp_misr_compactor_if.slave  rsp,
    input  logic [SIG_W-1:0]      golden_sig,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [SIG_W-1:0]      signature,
    output logic [CNT_W-1:0]      patterns_seen
);

    state_t            state;
    logic [CNT_W-1:0]  target;
    logic [CNT_W-1:0]  seen_inc;
    logic              ready_q;
    logic              xfer;
    logic              load;
    logic [RESP_W-1:0] resp_eff;
    logic [SIG_W-1:0]  resp_ext;

    assign rsp.resp_ready = ready_q;
    assign xfer     = rsp.resp_valid && ready_q;
    assign load     = start && (state == IDLE || state == DONE);
    assign seen_inc = patterns_seen + CNT_W'(1);

`ifdef RESP_MISR_XMASK_EN
    assign resp_eff = rsp.resp_data & ~rsp.resp_xmask;
`else
    assign resp_eff = rsp.resp_data;
`endif

    assign resp_ext = SIG_W'(resp_eff);

    misr_reg #(
        .SIG_W (SIG_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (xfer),
        .data  (resp_ext),
        .sig   (signature)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            target        <= '0;
            patterns_seen <= '0;
            ready_q       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        target        <= pat_count;
                        patterns_seen <= '0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        if (pat_count == '0) begin
                            state <= CHECK;
                        end else begin
                            state   <= RUN;
                            ready_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (xfer) begin
                        patterns_seen <= seen_inc;
                        if (seen_inc == target) begin
                            state   <= CHECK;
                            ready_q <= 1'b0;
                        end
                    end
                end
                CHECK: begin
                    pass  <= (signature == golden_sig);
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
